// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle datapath controller.
package mc_pkg;

    localparam int OPW_DEF = 6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    typedef struct packed {
        logic is_mem;   // lw or sw
        logic is_lw;
        logic is_r;
        logic is_beq;
        logic is_j;
        logic is_jal;
        logic is_imm;   // addi or ori
        logic is_ori;
        logic is_ill;
    } op_class_t;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier feeding the controller FSM.
module op_decode
    import mc_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic [OPW-1:0] op,
    output op_class_t      cls
);

    // One class flag per supported opcode group; anything else is illegal.
    always_comb begin
        cls = '0;
        case (op)
            OPW'(OP_RTYPE): cls.is_r = 1'b1;
            OPW'(OP_LW):    begin cls.is_mem = 1'b1; cls.is_lw = 1'b1; end
            OPW'(OP_SW):    cls.is_mem = 1'b1;
            OPW'(OP_BEQ):   cls.is_beq = 1'b1;
            OPW'(OP_J):     cls.is_j = 1'b1;
            OPW'(OP_JAL):   cls.is_jal = 1'b1;
            OPW'(OP_ADDI):  cls.is_imm = 1'b1;
            OPW'(OP_ORI):   begin cls.is_imm = 1'b1; cls.is_ori = 1'b1; end
            default:        cls.is_ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style controller: Moore FSM driving datapath enables and selects.
//
// state  | meaning
// FETCH  | read instruction, PC+4; wait for mem_rdy
// DECODE | register read, branch target compute, dispatch on opcode
// MEMADR | effective address for lw/sw
// MEMRD  | data read, held until mem_rdy
// MEMWB  | MDR -> rt
// MEMWR  | data write, held until mem_rdy
// EXEC   | R-type ALU operation
// RWB    | ALUOut -> rd
// BRANCH | beq compare, PC <- target when zero
// IEXEC  | addi/ori ALU operation
// IWB    | ALUOut -> rt
// JUMP   | PC <- jump target
// JAL    | PC <- jump target, PC+4 -> $31
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    input  logic           mem_rdy,
    output logic           PCWr,
    output logic           IRWr,
    output logic           RegWr,
    output logic           MemWr,
    output logic           IorD,
    output logic           ALUSrcA,
    output logic           ExtOp,
    output logic [1:0]     RegDst,
    output logic [1:0]     WDSel,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     PCSrc,
    output logic [1:0]     ALUOp,
    output logic           ill_op
);

    state_t    state_q, state_d;
    op_class_t cls;

    op_decode #(.OPW(OPW)) u_op_decode (
        .op  (op),
        .cls (cls)
    );

    // State register; reset returns to FETCH without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next state and Moore outputs; outputs are forced low while reset is held.
    always_comb begin
        state_d = state_q;
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RegWr   = 1'b0;
        MemWr   = 1'b0;
        IorD    = 1'b0;
        ALUSrcA = 1'b0;
        ExtOp   = 1'b0;
        RegDst  = 2'b00;
        WDSel   = 2'b00;
        ALUSrcB = 2'b00;
        PCSrc   = 2'b00;
        ALUOp   = 2'b00;
        ill_op  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB = 2'b01;
                    IRWr    = mem_rdy;
                    PCWr    = mem_rdy;
                    if (mem_rdy) state_d = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                    if      (cls.is_mem) state_d = S_MEMADR;
                    else if (cls.is_r)   state_d = S_EXEC;
                    else if (cls.is_beq) state_d = S_BRANCH;
                    else if (cls.is_j)   state_d = S_JUMP;
                    else if (cls.is_jal) state_d = S_JAL;
                    else if (cls.is_imm) state_d = S_IEXEC;
                    else begin
                        ill_op  = cls.is_ill;
                        state_d = S_FETCH;
                    end
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ExtOp   = 1'b1;
                    state_d = cls.is_lw ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    IorD = 1'b1;
                    if (mem_rdy) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    WDSel   = 2'b01;
                    RegWr   = 1'b1;
                    state_d = S_FETCH;
                end
                S_MEMWR: begin
                    IorD  = 1'b1;
                    MemWr = 1'b1;
                    if (mem_rdy) state_d = S_FETCH;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                    state_d = S_RWB;
                end
                S_RWB: begin
                    RegDst  = 2'b01;
                    RegWr   = 1'b1;
                    state_d = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b01;
                    PCSrc   = 2'b01;
                    PCWr    = zero;
                    state_d = S_FETCH;
                end
                S_IEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ExtOp   = !cls.is_ori;
                    ALUOp   = cls.is_ori ? 2'b11 : 2'b00;
                    state_d = S_IWB;
                end
                S_IWB: begin
                    RegWr   = 1'b1;
                    state_d = S_FETCH;
                end
                S_JUMP: begin
                    PCSrc   = 2'b10;
                    PCWr    = 1'b1;
                    state_d = S_FETCH;
                end
                S_JAL: begin
                    PCSrc   = 2'b10;
                    PCWr    = 1'b1;
                    RegDst  = 2'b10;
                    WDSel   = 2'b10;
                    RegWr   = 1'b1;
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-instruction expected output sequences built from the
// instruction's class and the chosen mem_rdy stall pattern.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       mem_rdy;
    logic       PCWr, IRWr, RegWr, MemWr, IorD, ALUSrcA, ExtOp, ill_op;
    logic [1:0] RegDst, WDSel, ALUSrcB, PCSrc, ALUOp;

    multicycle_ctrl #(.OPW(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .zero    (zero),
        .mem_rdy (mem_rdy),
        .PCWr    (PCWr),
        .IRWr    (IRWr),
        .RegWr   (RegWr),
        .MemWr   (MemWr),
        .IorD    (IorD),
        .ALUSrcA (ALUSrcA),
        .ExtOp   (ExtOp),
        .RegDst  (RegDst),
        .WDSel   (WDSel),
        .ALUSrcB (ALUSrcB),
        .PCSrc   (PCSrc),
        .ALUOp   (ALUOp),
        .ill_op  (ill_op)
    );

    always #5 clk = ~clk;

    logic [17:0] dut_vec;
    assign dut_vec = {PCWr, IRWr, RegWr, MemWr, IorD, ALUSrcA, ExtOp,
                      RegDst, WDSel, ALUSrcB, PCSrc, ALUOp, ill_op};

    typedef struct {
        logic [17:0] v;
        logic        rdy;
        logic        z;
    } step_t;

    step_t q[$];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic logic [17:0] mk(
        input logic pcwr, input logic irwr, input logic regwr, input logic memwr,
        input logic iord, input logic srca, input logic ext,
        input logic [1:0] regdst, input logic [1:0] wdsel, input logic [1:0] srcb,
        input logic [1:0] pcsrc, input logic [1:0] aluop, input logic ill);
        return {pcwr, irwr, regwr, memwr, iord, srca, ext,
                regdst, wdsel, srcb, pcsrc, aluop, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic [17:0] v, input logic rdy, input logic z);
        step_t s;
        s.v = v; s.rdy = rdy; s.z = z;
        q.push_back(s);
    endtask

    task automatic check(input string tag, input logic [17:0] exp);
        n_vec++;
        assert (dut_vec === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, dut_vec, exp);
        end
    endtask

    // Expected cycle-by-cycle outputs for one instruction.
    // fst: FETCH wait cycles, mst: memory wait cycles, zf: forced zero (-1 = random)
    task automatic build(input logic [5:0] opv, input int fst, input int mst, input int zf);
        logic ill;
        logic z;
        ill = !(opv inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b000010, 6'b000011, 6'b001000, 6'b001101});
        for (int i = 0; i < fst; i++) add(mk(0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00,0), 1'b0, rb());
        add(mk(1,1,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00,0), 1'b1, rb());
        add(mk(0,0,0,0,0,0,1, 2'b00,2'b00,2'b11,2'b00,2'b00,ill), rb(), rb());
        case (opv)
            6'b100011: begin
                add(mk(0,0,0,0,0,1,1, 2'b00,2'b00,2'b10,2'b00,2'b00,0), rb(), rb());
                for (int i = 0; i < mst; i++) add(mk(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,0), 1'b0, rb());
                add(mk(0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,0), 1'b1, rb());
                add(mk(0,0,1,0,0,0,0, 2'b00,2'b01,2'b00,2'b00,2'b00,0), rb(), rb());
            end
            6'b101011: begin
                add(mk(0,0,0,0,0,1,1, 2'b00,2'b00,2'b10,2'b00,2'b00,0), rb(), rb());
                for (int i = 0; i < mst; i++) add(mk(0,0,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,0), 1'b0, rb());
                add(mk(0,0,0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,0), 1'b1, rb());
            end
            6'b000000: begin
                add(mk(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00,2'b10,0), rb(), rb());
                add(mk(0,0,1,0,0,0,0, 2'b01,2'b00,2'b00,2'b00,2'b00,0), rb(), rb());
            end
            6'b000100: begin
                z = (zf < 0) ? rb() : 1'(zf);
                add(mk(z,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b01,2'b01,0), rb(), z);
            end
            6'b000010: add(mk(1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b10,2'b00,0), rb(), rb());
            6'b000011: add(mk(1,0,1,0,0,0,0, 2'b10,2'b10,2'b00,2'b10,2'b00,0), rb(), rb());
            6'b001000: begin
                add(mk(0,0,0,0,0,1,1, 2'b00,2'b00,2'b10,2'b00,2'b00,0), rb(), rb());
                add(mk(0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,0), rb(), rb());
            end
            6'b001101: begin
                add(mk(0,0,0,0,0,1,0, 2'b00,2'b00,2'b10,2'b00,2'b11,0), rb(), rb());
                add(mk(0,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,0), rb(), rb());
            end
            default: ;
        endcase
    endtask

    // Plays queued steps one cycle each; limit < 0 plays the whole queue.
    task automatic run(input string tag, input logic [5:0] opv, input int limit);
        step_t s;
        int    n;
        n = 0;
        while (q.size() > 0 && (limit < 0 || n < limit)) begin
            s = q.pop_front();
            @(negedge clk);
            if (n == 0) op = opv;
            mem_rdy = s.rdy;
            zero    = s.z;
            #1;
            check(tag, s.v);
            n++;
        end
    endtask

    // Async reset pulse in the middle of a cycle, no clock edge involved.
    task automatic mid_reset(input string tag);
        #1 rst = 1'b1;
        #1 check({tag, "_rst"}, 18'h0);
        rst = 1'b0;
        #1 check({tag, "_fetch"}, mk(0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00,0));
        q.delete();
    endtask

    logic [5:0] legal [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b000010, 6'b000011, 6'b001000, 6'b001101};

    initial begin
        logic [5:0] r;
        rst = 1'b1; mem_rdy = 1'b1; zero = 1'b1; op = 6'b100011;
        repeat (3) begin
            @(negedge clk); #1;
            check("rst_hold", 18'h0);
        end
        @(negedge clk);
        mem_rdy = 1'b0;
        rst = 1'b0;

        build(6'b100011, 0, 0, -1); run("lw", 6'b100011, -1);
        build(6'b101011, 0, 3, -1); run("sw_stall", 6'b101011, -1);
        build(6'b000100, 1, 0, 1);  run("beq_taken", 6'b000100, -1);
        build(6'b000100, 0, 0, 0);  run("beq_not", 6'b000100, -1);
        build(6'b000011, 0, 0, -1); run("jal", 6'b000011, -1);
        build(6'b111111, 0, 0, -1); run("ill", 6'b111111, -1);
        build(6'b000000, 2, 0, -1); run("rtype", 6'b000000, -1);

        build(6'b100011, 0, 3, -1); run("lw_pre", 6'b100011, 4);
        mid_reset("memrd");
        build(6'b101011, 0, 3, -1); run("sw_pre", 6'b101011, 5);
        mid_reset("memwr");

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 6'($urandom);
                while (r inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000010, 6'b000011, 6'b001000, 6'b001101})
                    r = 6'($urandom);
            end else begin
                r = legal[$urandom_range(0, 7)];
            end
            build(r, $urandom_range(0, 2), $urandom_range(0, 3), -1);
            run("rand", r, -1);
        end

        build(6'b001000, 0, 0, -1); run("addi", 6'b001000, -1);
        build(6'b001101, 0, 0, -1); run("ori", 6'b001101, -1);
        build(6'b000010, 0, 0, -1); run("j", 6'b000010, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter OPW, default 6, opcode field width.
REQ-002 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port op  in  OPW  instruction opcode IR[31:26], stable except on the cycle after IRWr.
REQ-005 SHALL have port zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_rdy  in  1  memory access complete this cycle.
REQ-007 SHALL have ports PCWr, IRWr, RegWr, MemWr  out  1 each  write enables.
REQ-008 SHALL have ports IorD, ALUSrcA, ExtOp  out  1 each  2-way selects; ExtOp 1 = sign, 0 = zero extend.
REQ-009 SHALL have ports RegDst, WDSel, ALUSrcB, PCSrc, ALUOp  out  2 each  4-way selects; bit0 = s0, bit1 = s1 of the driven mux.
REQ-010 SHALL have port ill_op  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-011 SHALL encode RegDst 00 = rt, 01 = rd, 10 = $31; WDSel 00 = ALUOut, 01 = MDR, 10 = PC; ALUSrcB 00 = B, 01 = 4, 10 = ext imm, 11 = ext imm<<2; PCSrc 00 = ALU, 01 = ALUOut, 10 = jump target; ALUOp 00 = add, 01 = sub, 10 = funct, 11 = or.
REQ-012 SHALL support opcodes R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, jal 000011, addi 001000, ori 001101.
REQ-013 SHALL be a Moore FSM; outputs depend on state only, except where mem_rdy or zero gating is stated below.
REQ-014 SHALL drive every output not listed for a state to 0.
REQ-015 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWr=PCWr=mem_rdy; goes to DECODE on mem_rdy, else holds.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=00.
REQ-017 DECODE next state: lw/sw -> MEMADR; R -> EXEC; beq -> BRANCH; j -> JUMP; jal -> JAL; addi/ori -> IEXEC; other -> FETCH with ill_op=1 for that cycle.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=00; goes to MEMRD (lw) or MEMWR (sw).
REQ-019 MEMRD: IorD=1; holds until mem_rdy, then goes to MEMWB.
REQ-020 MEMWB: RegDst=00, WDSel=01, RegWr=1; goes to FETCH.
REQ-021 MEMWR: IorD=1, MemWr=1, held each cycle until mem_rdy, then goes to FETCH.
REQ-022 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; goes to RWB.
REQ-023 RWB: RegDst=01, WDSel=00, RegWr=1; goes to FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWr=zero; goes to FETCH.
REQ-025 IEXEC: ALUSrcA=1, ALUSrcB=10; ExtOp=1, ALUOp=00 for addi; ExtOp=0, ALUOp=11 for ori; goes to IWB.
REQ-026 IWB: RegDst=00, WDSel=00, RegWr=1; goes to FETCH.
REQ-027 JUMP: PCSrc=10, PCWr=1; goes to FETCH.
REQ-028 JAL: PCSrc=10, PCWr=1, RegDst=10, WDSel=10, RegWr=1; writes PC+4 to $31; goes to FETCH.
REQ-029 Latency without stalls: lw 5 cycles; sw, R, addi, ori 4; beq, j, jal 3; each mem_rdy=0 cycle adds 1.
REQ-030 SHALL treat unused state codes as FETCH, with all outputs 0, returning to FETCH next edge.

Reset
REQ-031 rst=1 SHALL force state to FETCH immediately, with no clock edge required.
REQ-032 While rst=1, all write enables and ill_op SHALL be 0 and all selects SHALL be 0.
REQ-033 Reset asserted mid-instruction, including during a MemWr hold, SHALL abandon the instruction; the first FETCH after release SHALL start clean.

Structure
REQ-034 State codes (4-bit) and opcode constants SHALL live in shared package mc_pkg.
REQ-035 Opcode classification SHALL be one combinational sub-module op_decode, producing class flags for the FSM.

Verification
REQ-036 Reset release, mem_rdy=1, op=100011 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWr=1 with WDSel=01 on cycle 5.
REQ-037 op=101011, mem_rdy low 3 cycles in MEMWR -> MemWr=1 for 4 consecutive cycles, RegWr never 1.
REQ-038 op=000100: with zero=1 -> PCWr=1, PCSrc=01 in BRANCH; with zero=0 -> PCWr=0 in BRANCH.
REQ-039 op=000011 -> JAL cycle shows RegDst=10, WDSel=10, RegWr=1, PCWr=1, PCSrc=10.
REQ-040 op=111111 -> ill_op=1 for one cycle in DECODE, next state FETCH; rst pulsed mid-MEMRD -> outputs 0 asynchronously, FETCH after release.
